comparator_stream: RTL

- Parametrised, registered magnitude comparator with valid/ready handshaking on both sides. It is the streaming successor to the fixed 4-bit combinational comparator.
- Per accepted operand pair (a, b) it produces one-hot eq/gt/lt, in signed or unsigned mode selected per transaction.
- It keeps saturating per-outcome event counters for datapath monitoring and ML training-data statistics.
- It sits between an operand producer and a result consumer that may stall.

---
 rtl/comparator_pkg.sv | 33 +++
 rtl/comparator_core.sv | 37 +++
 rtl/comparator_stream.sv | 111 +++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// Shared types for the streaming magnitude comparator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package comparator_pkg;

  // Outcome of one compare; the 2-bit code 2'b11 is never produced.
  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_GT = 2'd1,
    CMP_LT = 2'd2
  } cmp_result_t;

  // One-hot flag bundle as presented on the result side.
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } flags_t;

  // Expand an encoded outcome into the one-hot {eq, gt, lt} flags.
  function automatic flags_t cmp_to_flags(input cmp_result_t r);
    flags_t f;
    f = '0;
    case (r)
      CMP_EQ:  f.eq = 1'b1;
      CMP_GT:  f.gt = 1'b1;
      CMP_LT:  f.lt = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/comparator_core.sv
// Combinational signed/unsigned magnitude compare of two WIDTH-bit operands.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output cmp_result_t      res
);

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so a single unsigned comparator serves both modes.
  logic [WIDTH-1:0] a_k;
  logic [WIDTH-1:0] b_k;

  // Bias the operands for signed mode, then compare as unsigned.
  always_comb begin
    a_k = a;
    b_k = b;
    if (is_signed) begin
      a_k[WIDTH-1] = ~a[WIDTH-1];
      b_k[WIDTH-1] = ~b[WIDTH-1];
    end
    if (a_k == b_k) begin
      res = CMP_EQ;
    end else if (a_k > b_k) begin
      res = CMP_GT;
    end else begin
      res = CMP_LT;
    end
  end

endmodule

// File: rtl/comparator_stream.sv
// Registered comparator with valid/ready on both sides and saturating outcome counters.
// Latency: 1 cycle from input acceptance to out_valid; one pair per cycle sustained.
// Backpressure: out_ready low holds the result and drops in_ready; counters count at acceptance.
module comparator_stream
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cmp_result_t      res;
  logic             in_fire;
  logic             out_fire;
  logic             out_valid_q;
  flags_t           flags_q;
  logic [CNT_W-1:0] cnt_eq_q, cnt_gt_q, cnt_lt_q;
  logic [CNT_W-1:0] cnt_eq_d, cnt_gt_d, cnt_lt_d;
  logic [CNT_W-1:0] base_eq, base_gt, base_lt;

  comparator_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a        (a),
    .b        (b),
    .is_signed(is_signed),
    .res      (res)
  );

  // Single-entry register: free, or being drained this cycle, means we can take a pair.
  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Result register: load on accept, drop valid once drained with nothing new behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else if (in_fire) begin
      out_valid_q <= 1'b1;
      flags_q     <= cmp_to_flags(res);
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Next counter values: apply clear first, then count the accepted outcome on top.
  always_comb begin
    base_eq  = cnt_clear ? '0 : cnt_eq_q;
    base_gt  = cnt_clear ? '0 : cnt_gt_q;
    base_lt  = cnt_clear ? '0 : cnt_lt_q;
    cnt_eq_d = base_eq;
    cnt_gt_d = base_gt;
    cnt_lt_d = base_lt;
    if (in_fire) begin
      case (res)
        CMP_EQ:  cnt_eq_d = sat_inc(base_eq);
        CMP_GT:  cnt_gt_d = sat_inc(base_gt);
        CMP_LT:  cnt_lt_d = sat_inc(base_lt);
        default: ;
      endcase
    end
  end

  // Outcome counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_eq_q <= '0;
      cnt_gt_q <= '0;
      cnt_lt_q <= '0;
    end else begin
      cnt_eq_q <= cnt_eq_d;
      cnt_gt_q <= cnt_gt_d;
      cnt_lt_q <= cnt_lt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign eq        = flags_q.eq;
  assign gt        = flags_q.gt;
  assign lt        = flags_q.lt;
  assign cnt_eq    = cnt_eq_q;
  assign cnt_gt    = cnt_gt_q;
  assign cnt_lt    = cnt_lt_q;

endmodule
